// File: rtl/vga_timing.sv
// VGA raster generator: pixel/line counters, registered sync and blanked RGB.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_count output.
module vga_timing #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] color,
  input  logic       display_enable,
  output logic [9:0] colPos,
  output logic [9:0] rowPos,
  output logic       visible,
  output logic       hsync,
  output logic       vsync,
  output logic [5:0] rgb,
`ifdef VGA_FRAME_CNT_EN
  output logic [15:0] frame_count,
`endif
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("vga_timing: H_TOTAL or V_TOTAL exceeds the 10-bit counter range");
  end

  localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);
  localparam logic [9:0] HVis       = 10'(H_VISIBLE);
  localparam logic [9:0] VVis       = 10'(V_VISIBLE);
  localparam logic [9:0] HSyncStart = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HSyncEnd   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VSyncStart = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VSyncEnd   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] col_q, col_d, row_q, row_d;
  logic       h_wrap, v_wrap, hsync_c, vsync_c, frame_end;
  logic [5:0] rgb_d;

  always_comb begin
    h_wrap    = (col_q == HLast);
    v_wrap    = (row_q == VLast);
    frame_end = h_wrap && v_wrap;
    col_d     = h_wrap ? 10'd0 : col_q + 10'd1;
    row_d     = row_q;
    if (h_wrap) begin
      row_d = v_wrap ? 10'd0 : row_q + 10'd1;
    end
    visible = (col_q < HVis) && (row_q < VVis);
    hsync_c = !((col_q >= HSyncStart) && (col_q < HSyncEnd));
    // Evaluated per pixel, so vsync edges fall on colPos 0 of the sync lines.
    vsync_c = !((row_q >= VSyncStart) && (row_q < VSyncEnd));
    rgb_d   = (visible && display_enable) ? color : 6'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q       <= 10'd0;
      row_q       <= 10'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb         <= 6'd0;
      frame_start <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hsync       <= hsync_c;
      vsync       <= vsync_c;
      rgb         <= rgb_d;
      frame_start <= frame_end;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_count_q;

  // Steps on the same edge that raises frame_start; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_count_q <= 16'd0;
    end else if (frame_end) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign frame_count = frame_count_q;
`endif

  assign colPos = col_q;
  assign rowPos = row_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing using a shrunken raster (17 x 13, 221-clock frame).
module tb_vga_timing;

  // hsync_c low for col 12..14, vsync_c low for rows 8..9.
  localparam int HV = 10, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;   // 17
  localparam int VT = VV + VF + VS + VB;   // 13
  localparam int FT = HT * VT;             // 221

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] color;
  logic       display_enable;
  logic [9:0] colPos, rowPos;
  logic       visible, hsync, vsync, frame_start;
  logic [5:0] rgb;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  vga_timing #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .color          (color),
    .display_enable (display_enable),
    .colPos         (colPos),
    .rowPos         (rowPos),
    .visible        (visible),
    .hsync          (hsync),
    .vsync          (vsync),
    .rgb            (rgb),
`ifdef VGA_FRAME_CNT_EN
    .frame_count    (frame_count),
`endif
    .frame_start    (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;      // posedges since reset release
    logic [5:0] color;  // inputs held during the interval leading up to t
    logic       de;
    int         col;
    int         row;
    logic       hs;
    logic       vs;
    logic [5:0] rgb;
    logic       fs;
    int         fc;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t vecs[20];
  int   cur;
  int   cnt, cnt2, first_low, guard;

  initial begin
    //        t    color  de col row hs  vs  rgb    fs  fc
    vecs[0]  = '{1,   6'h3F, 1, 1,  0,  1,  1,  6'h3F, 0,  0};
    vecs[1]  = '{10,  6'h3F, 1, 10, 0,  1,  1,  6'h3F, 0,  0};
    vecs[2]  = '{11,  6'h3F, 1, 11, 0,  1,  1,  6'h00, 0,  0};
    vecs[3]  = '{12,  6'h3F, 1, 12, 0,  1,  1,  6'h00, 0,  0};
    vecs[4]  = '{13,  6'h3F, 1, 13, 0,  0,  1,  6'h00, 0,  0};
    vecs[5]  = '{15,  6'h3F, 1, 15, 0,  0,  1,  6'h00, 0,  0};
    vecs[6]  = '{16,  6'h3F, 1, 16, 0,  1,  1,  6'h00, 0,  0};
    vecs[7]  = '{17,  6'h3F, 1, 0,  1,  1,  1,  6'h00, 0,  0};
    vecs[8]  = '{18,  6'h3F, 1, 1,  1,  1,  1,  6'h3F, 0,  0};
    vecs[9]  = '{20,  6'h15, 0, 3,  1,  1,  1,  6'h00, 0,  0};
    vecs[10] = '{21,  6'h2A, 1, 4,  1,  1,  1,  6'h2A, 0,  0};
    vecs[11] = '{102, 6'h2A, 1, 0,  6,  1,  1,  6'h00, 0,  0};
    vecs[12] = '{103, 6'h2A, 1, 1,  6,  1,  1,  6'h00, 0,  0};
    vecs[13] = '{136, 6'h2A, 1, 0,  8,  1,  1,  6'h00, 0,  0};
    vecs[14] = '{137, 6'h2A, 1, 1,  8,  1,  0,  6'h00, 0,  0};
    vecs[15] = '{170, 6'h2A, 1, 0,  10, 1,  0,  6'h00, 0,  0};
    vecs[16] = '{171, 6'h2A, 1, 1,  10, 1,  1,  6'h00, 0,  0};
    vecs[17] = '{220, 6'h2A, 1, 16, 12, 1,  1,  6'h00, 0,  0};
    vecs[18] = '{221, 6'h2A, 1, 0,  0,  1,  1,  6'h00, 1,  1};
    vecs[19] = '{222, 6'h2A, 1, 1,  0,  1,  1,  6'h2A, 0,  1};

    rst_n = 1'b0;
    color = 6'h3F;
    display_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset colPos", int'(colPos), 0);
    check("reset rowPos", int'(rowPos), 0);
    check("reset hsync", int'(hsync), 1);
    check("reset vsync", int'(vsync), 1);
    check("reset rgb", int'(rgb), 0);
    check("reset frame_start", int'(frame_start), 0);
    rst_n = 1'b1;

    cur = 0;
    foreach (vecs[i]) begin
      color = vecs[i].color;
      display_enable = vecs[i].de;
      tick(vecs[i].t - cur);
      cur = vecs[i].t;
      check($sformatf("v%0d colPos", i), int'(colPos), vecs[i].col);
      check($sformatf("v%0d rowPos", i), int'(rowPos), vecs[i].row);
      check($sformatf("v%0d hsync", i), int'(hsync), int'(vecs[i].hs));
      check($sformatf("v%0d vsync", i), int'(vsync), int'(vecs[i].vs));
      check($sformatf("v%0d rgb", i), int'(rgb), int'(vecs[i].rgb));
      check($sformatf("v%0d frame_start", i), int'(frame_start), int'(vecs[i].fs));
`ifdef VGA_FRAME_CNT_EN
      check($sformatf("v%0d frame_count", i), int'(frame_count), vecs[i].fc);
`endif
    end

    // Line: hsync first low 13 clocks after colPos=0, low for HS clocks.
    guard = 0;
    while (colPos != 10'd0 && guard < 2 * HT) begin
      tick(1);
      guard++;
    end
    check("align to col 0", int'(colPos), 0);
    cnt = 0;
    first_low = -1;
    for (int k = 1; k <= HT; k++) begin
      tick(1);
      if (!hsync) begin
        cnt++;
        if (first_low < 0) first_low = k;
      end
    end
    check("hsync first low offset", first_low, HV + HF + 1);
    check("hsync low width", cnt, HS);
    check("line period colPos", int'(colPos), 0);

    // Frame: vsync low run and frame_start pulse count over one frame period.
    cnt = 0;
    cnt2 = 0;
    for (int k = 0; k < FT; k++) begin
      tick(1);
      if (!vsync) cnt++;
      if (frame_start) cnt2++;
    end
    check("vsync low clocks", cnt, VS * HT);
    check("frame_start pulses per frame", cnt2, 1);

    // Frame period between consecutive frame_start pulses.
    guard = 0;
    while (!frame_start && guard < 2 * FT) begin
      tick(1);
      guard++;
    end
    check("frame_start seen", int'(frame_start), 1);
    cnt = 0;
    do begin
      tick(1);
      cnt++;
    end while (!frame_start && cnt < 2 * FT);
    check("frame period", cnt, FT);

    // Mid-frame reset at (13,8), where both syncs would otherwise go low.
    guard = 0;
    while (!(colPos == 10'd13 && rowPos == 10'd8) && guard < 2 * FT) begin
      tick(1);
      guard++;
    end
    check("reach (13,8)", int'(rowPos) * 1000 + int'(colPos), 8013);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("midrst colPos", int'(colPos), 0);
    check("midrst rowPos", int'(rowPos), 0);
    check("midrst hsync", int'(hsync), 1);
    check("midrst vsync", int'(vsync), 1);
    check("midrst rgb", int'(rgb), 0);
    check("midrst frame_start", int'(frame_start), 0);
`ifdef VGA_FRAME_CNT_EN
    check("midrst frame_count", int'(frame_count), 0);
`endif
    cnt = 0;
    do begin
      tick(1);
      cnt++;
    end while (!frame_start && cnt < 2 * FT);
    check("first frame_start after reset", cnt, FT);
`ifdef VGA_FRAME_CNT_EN
    check("frame_count after 1 frame", int'(frame_count), 1);
    for (int f = 2; f <= 3; f++) begin
      tick(FT);
      check("frame_start at frame boundary", int'(frame_start), 1);
      check("frame_count stepping", int'(frame_count), f);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Produces the VGA raster for the display path: pixel/line counters, hsync/vsync, and the current scan position.
- Drives colPos/rowPos into the pattern generator. Takes back its 6-bit color and display_enable.
- Outputs registered, blanked RGB aligned with registered sync to the DAC pins.
- Runs from a single pixel clock (25.175 MHz nominal for 640x480@60).

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
clk  input  1  pixel clock
rst_n  input  1  synchronous active-low reset
color  input  6  pattern color {R[1:0],G[1:0],B[1:0]} for current colPos/rowPos
display_enable  input  1  pattern says pixel is drawable
colPos  output  10  current horizontal count, 0..H_TOTAL-1
rowPos  output  10  current vertical count, 0..V_TOTAL-1
visible  output  1  combinational: colPos<H_VISIBLE && rowPos<V_VISIBLE
hsync  output  1  registered, active low
vsync  output  1  registered, active low
rgb  output  6  registered pixel to DAC
frame_start  output  1  one-cycle pulse at the start of each frame

Behaviour:
- H_TOTAL = sum of H_* parameters (800). V_TOTAL = sum of V_* parameters (525). Counters are 10 bits. Elaboration fails if either total exceeds 1024.
- Reset is synchronous and active-low. One clock; all state is updated on posedge clk.
- Reset values: colPos=0, rowPos=0, hsync=1, vsync=1, rgb=0, frame_start=0.
- Horizontal counter: increments every clock. At H_TOTAL-1 it wraps to 0.
- Vertical counter: increments only on the clock where colPos wraps. At V_TOTAL-1 it wraps to 0.
- Simultaneous wrap: at (799,524) the next cycle is (0,0).
- Sync timing, pre-register:
  - hsync_c = 0 iff H_VISIBLE+H_FRONT <= colPos < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - vsync_c = 0 iff V_VISIBLE+V_FRONT <= rowPos < V_VISIBLE+V_FRONT+V_SYNC, i.e. lines 490..491.
  - vsync_c is evaluated per pixel, so the vsync edges land at colPos=0 of those lines.
- Output pipeline, latency 1:
  - rgb <= (visible && display_enable) ? color : 0.
  - hsync <= hsync_c and vsync <= vsync_c, in the same cycle as rgb.
  - rgb, hsync and vsync therefore all describe the position that was on colPos/rowPos one cycle earlier.
- Blanking: rgb is 0 whenever the previous position was outside the visible area, regardless of color or display_enable.
- frame_start <= (colPos==H_TOTAL-1 && rowPos==V_TOTAL-1). It is high exactly in cycles where the counters read (0,0), but never in the first cycle after reset.
- Reset mid-frame: on the next edge, counters return to (0,0) and outputs return to their reset values. The first frame after reset has no frame_start pulse.
- Inputs color and display_enable are combinational from the pattern generator and sampled only at the rgb register. No other handshake.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- When defined:
  - Adds output frame_count [15:0], reset to 0.
  - frame_count increments by 1 in the same cycle frame_start is asserted.
  - It wraps 65535 -> 0.
  - Animated patterns use it as their time base.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset and first line: hold rst_n=0 for 3 clocks, then release. Required: colPos=0,1,2,… on consecutive clocks; rowPos=0; hsync=1, vsync=1, rgb=0 during reset.
- Line timing: after reset, count clocks. Required:
  - hsync falls exactly 657 clocks after colPos=0 (one-cycle register delay) and stays low 96 clocks.
  - The line period is 800 clocks.
  - rowPos increments when colPos goes 799 -> 0.
- Frame timing: run 800*525 clocks. Required:
  - vsync is low for exactly 1600 consecutive clocks, starting 1 clock after (0,490).
  - frame_start pulses once, when the counters read (0,0) after (799,524).
  - Frame period is 420000 clocks.
- Blanking and alignment: drive color=6'h3F, display_enable=1. Required:
  - rgb=6'h3F in the cycle after colPos=0..639 on rows 0..479.
  - rgb=0 in the cycle after colPos=640 and after rowPos=480.
  - With display_enable=0, rgb=0 everywhere.
- Mid-frame reset: assert rst_n=0 for 1 clock at (123,300). Required:
  - Next cycle colPos=0, rowPos=0, hsync=1, vsync=1, rgb=0, frame_start=0.
  - No frame_start until a full 420000-clock frame has elapsed.
- VGA_FRAME_CNT_EN build: run 3 frames. Required: frame_count = 0,1,2,3, stepping in the frame_start cycles. Force-start at 65535: one frame later it reads 0.
